fwd_hazard_ctrl: RTL
====================

Name: fwd_hazard_ctrl

Overview:
- Control-side driver for the EX-stage operand muxes of the pipelined MIPS. It produces the 2-bit select codes for the A and B 4-input muxes.
- Keeps a shadow pipeline of destination-register/write-enable info for the ID/EX, EX/MEM and MEM/WB stages.
- Issues registered forwarding selects, a load-use STALL, and a bubble request into ID/EX.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- SEL_W, 2, operand-mux select width. Fixed at 2; any other value is illegal.

Ports:
- CLK, input, 1, the single clock.
- RST, input, 1, synchronous, active-high reset.
- ID_VALID, input, 1, the ID stage holds a real instruction.
- ID_RS, input, REG_ADDR_W, source register A of the instruction in ID.
- ID_RT, input, REG_ADDR_W, source register B of the instruction in ID.
- ID_USES_RT, input, 1, the instruction reads RT as an ALU operand.
- ID_DEST, input, REG_ADDR_W, destination register after RegDst selection.
- ID_REGWRITE, input, 1, the instruction writes the register file.
- ID_IS_LOAD, input, 1, the instruction is lw.
- FLUSH, input, 1, branch/jump taken; the ID instruction is squashed.
- FWD_A_SEL, output, SEL_W, select for the A operand mux.
- FWD_B_SEL, output, SEL_W, select for the B operand mux.
- STALL, output, 1, hold PC and IF/ID this cycle.
- BUBBLE, output, 1, datapath must zero ID/EX control this edge.

Behaviour:
- Reset behaviour: when RST=1 at a CLK edge:
  - all shadow stages are cleared (dest=0, regwrite=0, is_load=0);
  - FWD_A_SEL and FWD_B_SEL go to 00;
  - STALL and BUBBLE are held low while RST=1;
  - RST overrides FLUSH and STALL.
- Select encoding:
  - 00 = register file (mux input 1);
  - 01 = MEM/WB result (input 2);
  - 10 = EX/MEM ALU result (input 3);
  - 11 is reserved and never driven.
- STALL (combinational):
  - STALL = ID_VALID & !FLUSH & idex.regwrite & idex.is_load & idex.dest!=0 & (idex.dest==ID_RS | (ID_USES_RT & idex.dest==ID_RT)).
  - BUBBLE = STALL | FLUSH.
- Shadow pipeline, on each non-reset edge:
  - memwb <= exmem;
  - exmem <= idex;
  - idex <= ID fields if (ID_VALID & !BUBBLE), else a bubble (regwrite=0, is_load=0, dest=0).
- Selects are registered and valid the cycle the instruction occupies EX, i.e. one cycle after ID. They are computed from pre-edge state:
  - A: if BUBBLE or !ID_VALID -> 00;
  - elif ID_RS!=0 & idex.regwrite & idex.dest==ID_RS -> 10;
  - elif ID_RS!=0 & exmem.regwrite & exmem.dest==ID_RS -> 01;
  - else 00.
  - B: same rules using ID_RT, additionally gated by ID_USES_RT (00 if clear).
- Priority: the younger producer (10) wins over the older (01) when both match.
- Register $0 never forwards, even if a stage claims to write it.
- Load-use: a load in idex matching a source raises STALL for exactly one cycle. The bubble then separates the two instructions, so the load reaches MEM/WB when the consumer reaches EX and the consumer gets 01. The consumer never sees 10 from a load.
- FLUSH and STALL in the same cycle: FLUSH dominates, STALL=0, bubble inserted.
- Back-to-back loads to the same register: each consumer stall is evaluated independently; there is no stall chaining beyond one cycle per consumer.

Optional Feature:
- Macro: FWD_HAZARD_STATS_EN.
- Defined:
  - adds output STALL_CNT [31:0], counting cycles with STALL=1;
  - adds output FWD_CNT [31:0], counting edges where either registered select becomes non-00;
  - both counters clear on RST and wrap at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package fwd_pkg:
  - REG_ADDR_W;
  - select localparams SEL_RF=2'b00, SEL_WB=2'b01, SEL_MEM=2'b10;
  - shadow-stage struct/typedef {dest, regwrite, is_load}.
- Sub-module fwd_src_cmp:
  - compares one source register against idex/exmem and returns the next select code;
  - instantiated twice (A, B).

Test Plan:
- Reset: assert RST for 2 cycles with random ID inputs -> FWD_*_SEL=00, STALL=0, BUBBLE=0; after release, an add with no dependencies -> selects stay 00.
- EX-EX forward: add $3,$1,$2 then sub $4,$3,$5 on consecutive cycles -> FWD_A_SEL=10 while sub is in EX; FWD_B_SEL=00.
- MEM-EX forward and priority:
  - add $3; nop; or $6,$7,$3 -> FWD_B_SEL=01.
  - add $3; add $3; and $8,$3,$3 -> both selects 10.
- Load-use: lw $2,0($1) then add $4,$2,$5 -> STALL=1 and BUBBLE=1 for exactly 1 cycle; the next cycle STALL=0; when add is in EX, FWD_A_SEL=01.
- Zero register and ID_USES_RT:
  - add $0,$1,$1 then add $5,$0,$0 -> selects 00;
  - lw $9 then addi $4,$1,4 with ID_RT=9 and ID_USES_RT=0 -> STALL=0.
- FLUSH with a load-use condition present -> STALL=0, BUBBLE=1; the next-cycle selects are 00 and no forward targets the squashed instruction's dest.

Source files
------------

// File: rtl/fwd_pkg.sv
// ============================================================================
// Module      : fwd_pkg
// Description : Shared widths, operand-mux select codes and shadow-stage types
//               for the EX-stage forwarding / hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fwd_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int SEL_W      = 2;

    localparam logic [SEL_W-1:0] SEL_RF  = 2'b00;
    localparam logic [SEL_W-1:0] SEL_WB  = 2'b01;
    localparam logic [SEL_W-1:0] SEL_MEM = 2'b10;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic                  regwrite;
        logic                  is_load;
    } stage_t;

    // Beyond ID/EX only the write target matters; load-ness is resolved by then.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic                  regwrite;
    } wr_t;

    localparam stage_t STAGE_EMPTY = '{dest: '0, regwrite: 1'b0, is_load: 1'b0};
    localparam wr_t    WR_EMPTY    = '{dest: '0, regwrite: 1'b0};

endpackage

`default_nettype wire

// File: rtl/fwd_src_cmp.sv
// ============================================================================
// Module      : fwd_src_cmp
// Description : Compares one source register against the ID/EX and EX/MEM
//               shadow stages and returns the next operand-mux select.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_src_cmp
    import fwd_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] i_src,
    input  logic                  i_src_en,
    input  stage_t                i_idex,
    input  wr_t                   i_exmem,
    output logic [SEL_W-1:0]      o_sel
);

    logic w_src_live;
    logic w_hit_mem;
    logic w_hit_wb;

    // A load in ID/EX has no ALU result to forward; the stall path handles it.
    always_comb begin
        w_src_live = i_src_en && (i_src != '0);
        w_hit_mem  = w_src_live && i_idex.regwrite && !i_idex.is_load &&
                     (i_idex.dest == i_src);
        w_hit_wb   = w_src_live && i_exmem.regwrite && (i_exmem.dest == i_src);
        o_sel      = SEL_RF;
        if (w_hit_mem) begin
            o_sel = SEL_MEM;
        end else if (w_hit_wb) begin
            o_sel = SEL_WB;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
// ============================================================================
// Module      : fwd_hazard_ctrl
// Description : Registered EX operand-mux selects, load-use STALL and ID/EX
//               bubble request. Optional counters under FWD_HAZARD_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_hazard_ctrl #(
    parameter int REG_ADDR_W = fwd_pkg::REG_ADDR_W,
    parameter int SEL_W      = fwd_pkg::SEL_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ID_VALID,
    input  logic [REG_ADDR_W-1:0] ID_RS,
    input  logic [REG_ADDR_W-1:0] ID_RT,
    input  logic                  ID_USES_RT,
    input  logic [REG_ADDR_W-1:0] ID_DEST,
    input  logic                  ID_REGWRITE,
    input  logic                  ID_IS_LOAD,
    input  logic                  FLUSH,
    output logic [SEL_W-1:0]      FWD_A_SEL,
    output logic [SEL_W-1:0]      FWD_B_SEL,
    output logic                  STALL,
    output logic                  BUBBLE
`ifdef FWD_HAZARD_STATS_EN
    ,
    output logic [31:0]           STALL_CNT,
    output logic [31:0]           FWD_CNT
`endif
);

    import fwd_pkg::*;

    stage_t             r_idex;
    wr_t                r_exmem;
    logic [SEL_W-1:0]   r_fwd_a_sel;
    logic [SEL_W-1:0]   r_fwd_b_sel;
    logic [SEL_W-1:0]   w_a_sel_nxt;
    logic [SEL_W-1:0]   w_b_sel_nxt;
    logic               w_ld_hit;
    logic               w_stall;
    logic               w_bubble;
    logic               w_issue;
    stage_t             w_id_stage;

    always_comb begin
        w_ld_hit = r_idex.regwrite && r_idex.is_load && (r_idex.dest != '0) &&
                   ((r_idex.dest == ID_RS) || (ID_USES_RT && (r_idex.dest == ID_RT)));
        w_stall  = ID_VALID && !FLUSH && w_ld_hit;
        w_bubble = w_stall || FLUSH;
        w_issue  = ID_VALID && !w_bubble;
        w_id_stage = STAGE_EMPTY;
        if (w_issue) begin
            w_id_stage = '{dest: ID_DEST, regwrite: ID_REGWRITE, is_load: ID_IS_LOAD};
        end
    end

    fwd_src_cmp u_cmp_a (
        .i_src    (ID_RS),
        .i_src_en (w_issue),
        .i_idex   (r_idex),
        .i_exmem  (r_exmem),
        .o_sel    (w_a_sel_nxt)
    );

    fwd_src_cmp u_cmp_b (
        .i_src    (ID_RT),
        .i_src_en (w_issue && ID_USES_RT),
        .i_idex   (r_idex),
        .i_exmem  (r_exmem),
        .o_sel    (w_b_sel_nxt)
    );

    // The MEM/WB shadow is implicit: whatever sits in EX/MEM while a consumer is
    // in ID occupies MEM/WB by the time that consumer reaches EX.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_idex      <= STAGE_EMPTY;
            r_exmem     <= WR_EMPTY;
            r_fwd_a_sel <= SEL_RF;
            r_fwd_b_sel <= SEL_RF;
        end else begin
            r_idex      <= w_id_stage;
            r_exmem     <= '{dest: r_idex.dest, regwrite: r_idex.regwrite};
            r_fwd_a_sel <= w_a_sel_nxt;
            r_fwd_b_sel <= w_b_sel_nxt;
        end
    end

    assign FWD_A_SEL = r_fwd_a_sel;
    assign FWD_B_SEL = r_fwd_b_sel;
    assign STALL     = w_stall && !RST;
    assign BUBBLE    = w_bubble && !RST;

`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_fwd_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if ((w_a_sel_nxt != SEL_RF) || (w_b_sel_nxt != SEL_RF)) begin
                r_fwd_cnt <= r_fwd_cnt + 32'd1;
            end
        end
    end

    assign STALL_CNT = r_stall_cnt;
    assign FWD_CNT   = r_fwd_cnt;
`endif

endmodule

`default_nettype wire
